grid_access_arbiter: RTL and testbench

- Shares the single-port 40x30 level grid RAM (3-bit cells: 0 air, 4 enemy, others wall/player/etc.) between up to NREQ requesters, e.g. renderer, player/collision logic, enemy updater.
- Grants exclusive, multi-cycle ownership with a round-robin policy and a hold timeout.
- Muxes the owner's address, write enable and write data to the RAM, and returns read data with a valid strobe.
- Sits between the game-logic FSMs and the grid memory instance.

---
 rtl/grid_access_arbiter_pkg.sv | 25 ++
 rtl/grid_access_arbiter_rr_picker.sv | 32 +++
 rtl/grid_access_arbiter.sv | 151 +++++++++++++++
 tb/tb_grid_access_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_access_arbiter_pkg.sv
// Shared constants for the level-grid access arbiter: grid geometry, cell codes, FSM states.
package grid_access_arbiter_pkg;

  localparam int GRID_W_DEF = 40;
  localparam int GRID_H_DEF = 30;
  localparam int X_W        = 6;
  localparam int Y_W        = 5;
  localparam int CELL_W     = 3;

  localparam logic [CELL_W-1:0] CELL_AIR    = 3'd0;
  localparam logic [CELL_W-1:0] CELL_WALL   = 3'd1;
  localparam logic [CELL_W-1:0] CELL_PLAYER = 3'd2;
  localparam logic [CELL_W-1:0] CELL_ENEMY  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/grid_access_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit searching upward from last_i+1, wrapping.
module grid_access_arbiter_rr_picker
  import grid_access_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  int cand;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_i) + k) % NREQ;
      if (!any_o && req_i[cand]) begin
        any_o          = 1'b1;
        onehot_o[cand] = 1'b1;
        idx_o          = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/grid_access_arbiter.sv
// Round-robin, multi-cycle owner arbiter for the single-port level grid RAM,
// with hold timeout, owner address/data mux and a registered read-valid pipeline.
module grid_access_arbiter
  import grid_access_arbiter_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int MAX_HOLD = 4096,
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [X_W*NREQ-1:0]    req_x,
  input  logic [Y_W*NREQ-1:0]    req_y,
  input  logic [NREQ-1:0]        req_we,
  input  logic [CELL_W*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rvalid,
  output logic [CELL_W-1:0]      rdata,
  output logic                   timeout,
  output logic [X_W-1:0]         grid_x,
  output logic [Y_W-1:0]         grid_y,
  output logic                   grid_write,
  output logic [CELL_W-1:0]      grid_in,
  input  logic [CELL_W-1:0]      grid_out
);

  localparam int IW = idx_w(NREQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]     last_q, last_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [NREQ-1:0]   rvalid_q, rvalid_d;
  logic              rd_oob_q, rd_oob_d;
  logic              timeout_q, timeout_d;
  logic [CELL_W-1:0] rdata_q;

  logic [NREQ-1:0]   pick_onehot;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;

  grid_access_arbiter_rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .req_i    (req),
    .last_i   (last_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // last_q always names the current owner while in OWN
  logic [X_W-1:0]    own_x;
  logic [Y_W-1:0]    own_y;
  logic [CELL_W-1:0] own_wd;
  logic              own_we, own_req, own_inb, is_own;

  assign own_x   = req_x[X_W*int'(last_q) +: X_W];
  assign own_y   = req_y[Y_W*int'(last_q) +: Y_W];
  assign own_wd  = req_wdata[CELL_W*int'(last_q) +: CELL_W];
  assign own_we  = req_we[last_q];
  assign own_req = req[last_q];
  assign own_inb = (int'(own_x) < GRID_W) && (int'(own_y) < GRID_H);
  assign is_own  = (state_q == ST_OWN);

  always_comb begin
    grid_x     = '0;
    grid_y     = '0;
    grid_in    = '0;
    grid_write = 1'b0;
    if (is_own) begin
      grid_x     = own_x;
      grid_y     = own_y;
      grid_in    = own_wd;
      grid_write = own_we && own_inb;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    rvalid_d  = '0;
    rd_oob_d  = 1'b0;
    if (is_own && !own_we) begin
      rvalid_d = gnt_q;
      rd_oob_d = !own_inb;
    end
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_onehot;
          last_d  = pick_idx;
          hold_d  = '0;
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        // a voluntary release takes precedence over a coincident timeout
        if (!own_req) begin
          gnt_d   = '0;
          state_d = ST_DRAIN;
        end else if (hold_q == HW'(MAX_HOLD - 1)) begin
          gnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = ST_DRAIN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // RAM read data arrives one cycle after the address, alongside the registered rvalid
  assign rdata = (|rvalid_q) ? (rd_oob_q ? CELL_AIR : grid_out) : rdata_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      last_q    <= IW'(NREQ - 1);
      hold_q    <= '0;
      rvalid_q  <= '0;
      rd_oob_q  <= 1'b0;
      timeout_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      rvalid_q  <= rvalid_d;
      rd_oob_q  <= rd_oob_d;
      timeout_q <= timeout_d;
      if (|rvalid_q) rdata_q <= rdata;
    end
  end

  assign gnt     = gnt_q;
  assign rvalid  = rvalid_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_grid_access_arbiter.sv
// Directed and random checks of grid_access_arbiter against a cycle-level reference model and RAM shadow.
module tb_grid_access_arbiter;

  localparam int NREQ = 3;
  localparam int MAXH = 8;
  localparam int GW   = 40;
  localparam int GH   = 30;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [6*NREQ-1:0] req_x;
  logic [5*NREQ-1:0] req_y;
  logic [NREQ-1:0]   req_we;
  logic [3*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   gnt, rvalid;
  logic [2:0]        rdata;
  logic              timeout;
  logic [5:0]        grid_x;
  logic [4:0]        grid_y;
  logic              grid_write;
  logic [2:0]        grid_in;
  logic [2:0]        grid_out = 3'd0;

  logic [5:0] rq_x  [NREQ];
  logic [4:0] rq_y  [NREQ];
  logic       rq_we [NREQ];
  logic [2:0] rq_wd [NREQ];

  always_comb begin
    req_x = '0; req_y = '0; req_we = '0; req_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_x[6*i +: 6]     = rq_x[i];
      req_y[5*i +: 5]     = rq_y[i];
      req_we[i]           = rq_we[i];
      req_wdata[3*i +: 3] = rq_wd[i];
    end
  end

  grid_access_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAXH), .GRID_W(GW), .GRID_H(GH)) dut (
    .clock(clock), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_we(req_we), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .timeout(timeout), .grid_x(grid_x), .grid_y(grid_y), .grid_write(grid_write),
    .grid_in(grid_in), .grid_out(grid_out)
  );

  always #5 clock = ~clock;

  // Grid RAM: synchronous read; out-of-range addresses read back a non-zero junk value.
  logic [2:0] mem    [GH][GW];
  logic [2:0] shadow [GH][GW];
  always @(posedge clock) begin
    if (int'(grid_x) < GW && int'(grid_y) < GH) begin
      grid_out <= mem[grid_y][grid_x];
      if (grid_write) mem[grid_y][grid_x] <= grid_in;
    end else begin
      grid_out <= 3'd7;
    end
  end

  int errors = 0;
  int checks = 0;

  int m_owner, m_drain, m_last, m_hold, m_rv, m_tout;
  logic [2:0] m_rvdata, m_rdhold;
  int left [NREQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bitof(input int i);
    return (i < 0) ? 32'd0 : (32'd1 << i);
  endfunction

  function automatic bit inb(input int x, input int y);
    return (x < GW) && (y < GH);
  endfunction

  task automatic model_reset();
    m_owner = -1; m_drain = 0; m_last = NREQ - 1; m_hold = 0;
    m_rv = -1; m_rvdata = 3'd0; m_rdhold = 3'd0; m_tout = 0;
  endtask

  // One clock cycle: compare outputs against the model at negedge, then advance the model.
  task automatic cycle();
    int o, x, y, n_rv;
    logic w;
    logic [14:0] ebus;
    logic [2:0] n_rvdata;
    @(negedge clock);
    o = m_owner;
    chk("gnt", gnt, bitof(o));
    chk("rvalid", rvalid, bitof(m_rv));
    chk("rdata", rdata, (m_rv >= 0) ? m_rvdata : m_rdhold);
    chk("timeout", timeout, m_tout);
    ebus = '0; w = 1'b0; x = 0; y = 0;
    if (o >= 0) begin
      x = int'(rq_x[o]); y = int'(rq_y[o]);
      w = rq_we[o] && inb(x, y);
      ebus = {w, rq_x[o], rq_y[o], rq_wd[o]};
    end
    chk("grid_bus", {grid_write, grid_x, grid_y, grid_in}, ebus);
    if (m_rv >= 0) m_rdhold = m_rvdata;
    n_rv = -1; n_rvdata = 3'd0;
    if (o >= 0 && !rq_we[o]) begin
      n_rv = o;
      n_rvdata = inb(x, y) ? shadow[y][x] : 3'd0;
    end
    if (w) shadow[y][x] = rq_wd[o];
    m_tout = 0;
    if (o >= 0) begin
      if (!req[o]) begin
        m_owner = -1; m_drain = 1;
      end else if (m_hold == MAXH - 1) begin
        m_owner = -1; m_drain = 1; m_tout = 1;
      end else begin
        m_hold++;
      end
    end else if (m_drain != 0) begin
      m_drain = 0;
    end else if (req != 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (m_owner < 0 && req[(m_last + k) % NREQ]) begin
          m_owner = (m_last + k) % NREQ;
        end
      end
      m_last = m_owner; m_hold = 0;
    end
    m_rv = n_rv; m_rvdata = n_rvdata;
    @(posedge clock);
    #1;
  endtask

  task automatic agent_step(input int budget, input bit rnd);
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        if (left[i] > 0) begin
          left[i]--;
          if (rnd) begin
            rq_x[i]  = 6'($urandom_range(0, 45));
            rq_y[i]  = 5'($urandom_range(0, 33));
            rq_we[i] = 1'($urandom_range(0, 1));
            rq_wd[i] = 3'($urandom_range(0, 7));
          end else begin
            rq_x[i]  = 6'($urandom_range(0, GW - 1));
            rq_y[i]  = 5'($urandom_range(0, GH - 1));
            rq_we[i] = 1'b0;
          end
        end else begin
          req[i] = 1'b0;
        end
      end else if (!req[i] && (!rnd || $urandom_range(0, 2) == 0)) begin
        req[i]  = 1'b1;
        left[i] = rnd ? int'($urandom_range(0, budget)) : budget;
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req = '0;
    for (int i = 0; i < NREQ; i++) left[i] = 0;
    model_reset();
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_write", grid_write, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  logic [2:0] s2_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  initial begin
    logic [2:0] order[$];
    int gaps[$];
    int gap, own2, touts;
    logic [2:0] prevg, nextg;

    for (int i = 0; i < NREQ; i++) begin
      rq_x[i] = '0; rq_y[i] = '0; rq_we[i] = 1'b0; rq_wd[i] = '0;
    end
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++) begin
        mem[y][x] = 3'($urandom_range(0, 7));
        shadow[y][x] = mem[y][x];
      end
    mem[7][5] = 3'd4;  shadow[7][5] = 3'd4;
    mem[3][10] = 3'd1; shadow[3][10] = 3'd1;

    apply_reset();

    // Single read by requester 0
    rq_x[0] = 6'd5; rq_y[0] = 5'd7; rq_we[0] = 1'b0; req = 3'b001;
    cycle();
    chk("s1_gnt", gnt, 3'b001);
    cycle();
    chk("s1_rvalid", rvalid, 3'b001);
    chk("s1_rdata", rdata, 3'd4);
    req = '0;
    repeat (3) cycle();

    // Round robin with all three requesting, two accesses per grant
    apply_reset();
    gap = 0; prevg = '0;
    for (int c = 0; c < 80 && order.size() < 4; c++) begin
      agent_step(2, 1'b0);
      cycle();
      chk("s2_onehot", $onehot0(gnt), 1);
      if (gnt != 0 && prevg == 0) begin
        order.push_back(gnt);
        gaps.push_back(gap);
      end
      gap = (gnt == 0) ? gap + 1 : 0;
      prevg = gnt;
    end
    chk("s2_grants", order.size(), 4);
    for (int k = 0; k < 4 && k < order.size(); k++) begin
      chk("s2_order", order[k], s2_exp[k]);
      if (k > 0) chk("s2_gap", gaps[k], 2);
    end
    req = '0;
    repeat (4) cycle();

    // Requester 1 writes a cell, then reads it back
    rq_x[1] = 6'd10; rq_y[1] = 5'd3; rq_we[1] = 1'b1; rq_wd[1] = 3'd4; req = 3'b010;
    cycle();
    chk("s3_gnt", gnt, 3'b010);
    cycle();
    rq_we[1] = 1'b0;
    cycle();
    chk("s3_rvalid", rvalid, 3'b010);
    chk("s3_rdata", rdata, 3'd4);
    req = '0;
    repeat (3) cycle();

    // Hold timeout: requester 2 never lets go while requester 0 waits
    rq_x[2] = 6'd1; rq_y[2] = 5'd1; rq_we[2] = 1'b0;
    rq_x[0] = 6'd2; rq_y[0] = 5'd2; rq_we[0] = 1'b0;
    req = 3'b101; own2 = 0; touts = 0; nextg = '0;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (gnt[2]) own2++;
      if (timeout) touts++;
      if (gnt == 3'b001) begin
        nextg = gnt;
        break;
      end
    end
    chk("s4_hold_cycles", own2, MAXH);
    chk("s4_timeouts", touts, 1);
    chk("s4_next_gnt", nextg, 3'b001);
    req = '0;
    repeat (3) cycle();

    // Out-of-bounds write and read
    rq_x[0] = 6'd40; rq_y[0] = 5'd0; rq_we[0] = 1'b1; rq_wd[0] = 3'd7; req = 3'b001;
    cycle();
    chk("s5_gnt", gnt, 3'b001);
    #1;
    chk("s5_oob_write", grid_write, 0);
    cycle();
    rq_x[0] = 6'd3; rq_y[0] = 5'd30; rq_we[0] = 1'b0;
    cycle();
    chk("s5_oob_rvalid", rvalid, 3'b001);
    chk("s5_oob_rdata", rdata, 3'd0);

    // Reset while owning with a read in flight
    rq_x[0] = 6'd5; rq_y[0] = 5'd7;
    cycle();
    chk("s6_rv_pending", rvalid, 3'b001);
    #2;
    reset = 1'b1;
    #1;
    chk("s6_rst_gnt", gnt, 0);
    chk("s6_rst_rvalid", rvalid, 0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    rq_x[1] = 6'd6; rq_y[1] = 5'd6; rq_we[1] = 1'b0;
    req = 3'b011;
    cycle();
    chk("s6_first_gnt", gnt, 3'b001);
    req = '0;
    repeat (3) cycle();

    // Random traffic including out-of-range addresses and hold timeouts
    for (int i = 0; i < NREQ; i++) left[i] = 0;
    for (int c = 0; c < 400; c++) begin
      agent_step(11, 1'b1);
      cycle();
    end
    req = '0;
    repeat (4) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
